soqpsk_lut_sequencer: RTL
=========================

Name: soqpsk_lut_sequencer

Overview:
Bit-level front end of the SOQPSK transmit chain. It consumes a serial bit stream over a valid/ready handshake and precodes it into the ternary SOQPSK alphabet. It tracks the carrier phase quadrant and generates per-sample addresses into the 512x14 waveform ROM (registered address and output, 2-cycle read). It also reads back and re-registers the ROM samples as the modulator output stream.

Parameters:
SPS_LOG2, 4, log2 samples per symbol; fixed at 4 by the 9-bit ROM address map
ROM_LATENCY, 2, clocks from rom_addr change to valid rom_q
DATA_W, 14, ROM/sample word width

Ports:
clock  in  1  system clock, all logic rising-edge
reset_n  in  1  synchronous reset, active low
enable  in  1  modulator enable; low forces IDLE
sample_en  in  1  one-cycle sample strobe from the rate NCO
bit_in  in  1  data bit (1 maps to +1, 0 maps to -1)
bit_valid  in  1  bit_in valid
bit_ready  out  1  bit accepted when bit_valid and bit_ready are both high
rom_addr  out  9  registered waveform ROM address
rom_q  in  14  ROM data, ROM_LATENCY clocks after rom_addr
sample_out  out  14  registered signed waveform sample
sample_valid  out  1  sample_out valid strobe
underrun  out  1  one-cycle pulse on missing bit at symbol boundary
busy  out  1  high in RUN

Behaviour:
- Reset (reset_n low at clock edge):
  - Outputs: rom_addr=0, sample_out=0, sample_valid=0, underrun=0, busy=0.
  - Internal state: state=IDLE, sample_cnt=0, quadrant=0, parity k=0, history a[k-1]=a[k-2]=+1, latency pipe cleared.
  - Reset wins over every other input.
- Address map: rom_addr = {quadrant[1:0], alpha[1:0], parity, sample_cnt[3:0]}.
  - alpha encoding: 00=0, 01=+1, 11=-1; 10 is never generated.
- Precoder: alpha_k = (-1)^(k+1) * a[k-1] * (a[k] - a[k-2]) / 2.
  - Computed when a symbol starts; history shifts after each accepted bit.
- States:
  - IDLE:
    - bit_ready = enable.
    - An accepted bit is precoded and latched; go to RUN.
    - sample_cnt=0; rom_addr is not updated.
  - RUN:
    - On each sample_en: rom_addr <= current symbol address; sample_cnt increments.
    - bit_ready = sample_en and (sample_cnt == 15), combinational.
  - Symbol boundary (sample_en with sample_cnt==15):
    - quadrant <= quadrant + alpha (mod 4); parity toggles; sample_cnt wraps to 0.
    - If a bit is accepted, it becomes the next symbol.
    - If bit_valid is low (underrun): underrun pulses for 1 cycle; next symbol uses alpha=0; history unchanged; parity still toggles; RUN continues.
  - enable low in any state: next cycle state=IDLE, sample_cnt=0, bit_ready=0. quadrant, parity and history are held. Samples already in the pipeline still emerge.
- Output pipeline:
  - Registered rom_addr is visible the cycle after sample_en; rom_q is valid ROM_LATENCY cycles later.
  - sample_out <= rom_q, with sample_valid high for one cycle.
  - Total latency from sample_en (cycle 0) to sample_valid is ROM_LATENCY+2 = 4 cycles, fully pipelined; back-to-back sample_en is legal.
- sample_en with no bit in IDLE: no address update, no sample_valid.
- sample_out holds its last value between strobes.

Test Plan:
- Reset: hold reset_n=0 for 3 clocks mid-RUN -> all outputs 0; first accepted bit then uses history +1,+1, quadrant 0, parity 0.
- Stream all ones, sample_en every cycle -> alpha=0 throughout, quadrant stays 0. Addresses 0x000..0x00F then 0x010..0x01F, repeating. sample_valid first seen 4 cycles after the first rom_addr-updating sample_en.
- Bits 1,0,1,0 -> alpha sequence 0,-1,0,0. Symbol 1 addresses 0x070..0x07F; symbol 2 addresses 0x180..0x18F, since quadrant becomes 3.
- Underrun: drop bit_valid at the symbol-2 boundary -> underrun pulses exactly once, symbol uses alpha=00, bit_ready seen high only on sample_cnt==15 strobes.
- enable deasserted at sample_cnt=7 -> IDLE next cycle, the 4 in-flight samples still emitted. Re-enable then resumes with the held quadrant and parity, sample_cnt=0.
- ROM readback: model the ROM with q=address -> sample_out equals the rom_addr value issued 4 cycles earlier, for 2 full symbols.

Source files
------------

// File: rtl/soqpsk_lut_sequencer.sv
// SOQPSK bit front end: precodes serial bits into the ternary alphabet, tracks
// the carrier quadrant and sequences waveform ROM addresses/samples.
module soqpsk_lut_sequencer #(
  parameter int SPS_LOG2    = 4,
  parameter int ROM_LATENCY = 2,
  parameter int DATA_W      = 14
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              sample_en,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic              bit_ready,
  output logic [8:0]        rom_addr,
  input  logic [DATA_W-1:0] rom_q,
  output logic [DATA_W-1:0] sample_out,
  output logic              sample_valid,
  output logic              underrun,
  output logic              busy
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                state, state_next;
  logic [SPS_LOG2-1:0]   sample_cnt;
  logic [1:0]            quadrant;
  logic [1:0]            alpha;
  logic                  parity;
  logic                  hist1, hist2;
  logic [ROM_LATENCY:0]  valid_pipe;

  logic                  step, boundary, accept, par_in;
  logic [1:0]            alpha_new;

  // Bits are 1 -> +1, 0 -> -1. The product sign is negative when an odd number
  // of the three factors (a_k - a_{k-2}, a_{k-1}, (-1)^(k+1)) are negative.
  function automatic logic [1:0] precode(input logic ak, input logic a1,
                                         input logic a2, input logic k);
    if (ak == a2)
      return 2'b00;
    else if (ak ^ a1 ^ k)
      return 2'b01;
    else
      return 2'b11;
  endfunction

  always_comb begin
    state_next = state;
    bit_ready  = 1'b0;
    step       = 1'b0;
    boundary   = 1'b0;
    if (!enable) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          bit_ready = 1'b1;
          if (bit_valid) state_next = RUN;
        end
        RUN: begin
          step      = sample_en;
          boundary  = sample_en && (sample_cnt == '1);
          bit_ready = boundary;
        end
        default: state_next = IDLE;
      endcase
    end
    bit_ready = bit_ready && reset_n;
    accept    = bit_ready && bit_valid;
    // A bit taken at a boundary belongs to the next symbol, hence the toggled parity.
    par_in    = (state == RUN) ? ~parity : parity;
    alpha_new = precode(bit_in, hist1, hist2, par_in);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state        <= IDLE;
      sample_cnt   <= '0;
      quadrant     <= '0;
      alpha        <= '0;
      parity       <= 1'b0;
      hist1        <= 1'b1;
      hist2        <= 1'b1;
      valid_pipe   <= '0;
      rom_addr     <= '0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      state        <= state_next;
      underrun     <= 1'b0;
      valid_pipe   <= {valid_pipe[ROM_LATENCY-1:0], step};
      sample_valid <= valid_pipe[ROM_LATENCY];
      if (valid_pipe[ROM_LATENCY]) sample_out <= rom_q;

      if (!enable || (state == IDLE)) begin
        sample_cnt <= '0;
      end else if (step) begin
        rom_addr   <= {quadrant, alpha, parity, sample_cnt};
        sample_cnt <= sample_cnt + SPS_LOG2'(1);
      end

      if (boundary) begin
        quadrant <= quadrant + alpha;
        parity   <= ~parity;
        if (!bit_valid) begin
          alpha    <= '0;
          underrun <= 1'b1;
        end
      end

      if (accept) begin
        alpha <= alpha_new;
        hist1 <= bit_in;
        hist2 <= hist1;
      end
    end
  end

  assign busy = (state == RUN);

endmodule
